// File: rtl/scr1_trc_pkg.sv
// rtl/scr1_trc_pkg.sv - shared types and constants for the imem capture tracer
// Purpose: response code encoding, trace record layout, reset pattern and the
//          masked compare helper used by the tracer top.
// Ports:   none (package)
package scr1_trc_pkg;

   typedef enum logic [1:0] {
      SCR1_TRC_RESP_IDLE  = 2'b00,
      SCR1_TRC_RESP_OKAY  = 2'b01,
      SCR1_TRC_RESP_ERROR = 2'b10
   } type_scr1_trc_resp_e;

   localparam int          SCR1_TRC_TS_W      = 32;
   localparam logic [31:0] SCR1_TRC_MATCH_RST = 32'h057E4505;
   localparam logic [31:0] SCR1_TRC_MASK_RST  = 32'hFFFFFFFF;

   // Record layout at the default timestamp width; the top builds the same
   // layout locally so the timestamp field can follow its own parameter.
   typedef struct packed {
      logic [31:0]              pc;
      logic [31:0]              instr;
      logic [SCR1_TRC_TS_W-1:0] ts;
   } type_scr1_trc_entry_s;

   // Only bits with a 1 in mask take part in the compare.
   function automatic logic trc_pattern_match(input logic [31:0] word,
                                              input logic [31:0] val,
                                              input logic [31:0] mask);
      return ((word ^ val) & mask) == 32'h0;
   endfunction

endpackage

// File: rtl/scr1_trc_fifo.sv
// rtl/scr1_trc_fifo.sv - generic synchronous FIFO with occupancy counter
// Purpose: stores trace records; full/empty come from the occupancy counter so
//          the pointers can stay log2(DEPTH) bits and wrap on their own.
// Ports:   clk, rst     - clock, synchronous active-high reset (flushes)
//          push, wdata  - write request and data; ignored when full unless a
//                         pop happens in the same cycle
//          pop, rdata   - read request and head data; ignored when empty
//          full, empty  - occupancy flags
//          level        - current number of stored entries
module scr1_trc_fifo
   import scr1_trc_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 96
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_pop;
   logic          do_push;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the slot this edge, so a full FIFO still accepts the push.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign level = cnt;

endmodule

// File: rtl/scr1_imem_cmd_tracer.sv
// rtl/scr1_imem_cmd_tracer.sv - masked-pattern capture of imem fetch responses
// Purpose: compares each OKAY fetch word against a masked pattern and buffers
//          {pc, instr, timestamp} of every hit for a ready/valid debug drain.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          imem_resp/imem_rdata/curr_pc - fetch response, word and its PC
//          cfg_en                      - capture enable
//          cfg_wr, cfg_wdata_val/mask  - pattern load strobe and new pattern
//          cfg_clr                     - clears ovf, drop_cnt, hit_cnt
//          trc_vd/trc_rdy              - drain handshake
//          trc_pc/trc_instr/trc_ts     - head record, zero while trc_vd = 0
//          trc_lvl                     - FIFO occupancy
//          ovf, drop_cnt, hit_cnt      - sticky overflow and saturating stats
module scr1_imem_cmd_tracer
   import scr1_trc_pkg::*;
#(
   parameter int          TRC_DEPTH     = 8,
   parameter int          TRC_TS_W      = 32,
   parameter logic [31:0] TRC_MATCH_RST = SCR1_TRC_MATCH_RST,
   parameter logic [31:0] TRC_MASK_RST  = SCR1_TRC_MASK_RST
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   imem_resp,
   input  logic [31:0]                  imem_rdata,
   input  logic [31:0]                  curr_pc,
   input  logic                         cfg_en,
   input  logic                         cfg_wr,
   input  logic [31:0]                  cfg_wdata_val,
   input  logic [31:0]                  cfg_wdata_mask,
   input  logic                         cfg_clr,
   output logic                         trc_vd,
   input  logic                         trc_rdy,
   output logic [31:0]                  trc_pc,
   output logic [31:0]                  trc_instr,
   output logic [TRC_TS_W-1:0]          trc_ts,
   output logic [$clog2(TRC_DEPTH):0]   trc_lvl,
   output logic                         ovf,
   output logic [15:0]                  drop_cnt,
   output logic [15:0]                  hit_cnt
);

   typedef struct packed {
      logic [31:0]         pc;
      logic [31:0]         instr;
      logic [TRC_TS_W-1:0] ts;
   } entry_t;

   logic [31:0]         cfg_match_val;
   logic [31:0]         cfg_match_mask;
   logic [TRC_TS_W-1:0] ts_cnt;
   logic                hit;
   logic                drop;
   logic                fifo_full;
   logic                fifo_empty;
   entry_t              push_entry;
   entry_t              head_entry;

   assign hit = cfg_en && (imem_resp == SCR1_TRC_RESP_OKAY) &&
                trc_pattern_match(imem_rdata, cfg_match_val, cfg_match_mask);

   // Full implies non-empty, so trc_rdy alone means a pop frees a slot.
   assign drop = hit && fifo_full && !trc_rdy;

   assign push_entry = '{pc: curr_pc, instr: imem_rdata, ts: ts_cnt};

   scr1_trc_fifo #(
      .DEPTH (TRC_DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hit),
      .wdata (push_entry),
      .pop   (trc_rdy),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (trc_lvl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt         <= '0;
         cfg_match_val  <= TRC_MATCH_RST;
         cfg_match_mask <= TRC_MASK_RST;
         ovf            <= 1'b0;
         drop_cnt       <= '0;
         hit_cnt        <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         // The compare in this cycle already used the old pattern.
         if (cfg_wr) begin
            cfg_match_val  <= cfg_wdata_val;
            cfg_match_mask <= cfg_wdata_mask;
         end
         // Clear has priority over a simultaneous hit or drop.
         if (cfg_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
            hit_cnt  <= '0;
         end else begin
            if (hit && (hit_cnt != 16'hFFFF)) begin
               hit_cnt <= hit_cnt + 16'd1;
            end
            if (drop) begin
               ovf <= 1'b1;
               if (drop_cnt != 16'hFFFF) begin
                  drop_cnt <= drop_cnt + 16'd1;
               end
            end
         end
      end
   end

   assign trc_vd    = !fifo_empty;
   assign trc_pc    = trc_vd ? head_entry.pc    : '0;
   assign trc_instr = trc_vd ? head_entry.instr : '0;
   assign trc_ts    = trc_vd ? head_entry.ts    : '0;

endmodule

// File: tb/tb_scr1_imem_cmd_tracer.sv
// tb/tb_scr1_imem_cmd_tracer.sv - scoreboard bench for scr1_imem_cmd_tracer
module tb_scr1_imem_cmd_tracer;
   import scr1_trc_pkg::*;

   localparam int DEPTH = 8;
   localparam int TSW   = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        imem_resp;
   logic [31:0]       imem_rdata;
   logic [31:0]       curr_pc;
   logic              cfg_en;
   logic              cfg_wr;
   logic [31:0]       cfg_wdata_val;
   logic [31:0]       cfg_wdata_mask;
   logic              cfg_clr;
   logic              trc_vd;
   logic              trc_rdy;
   logic [31:0]       trc_pc;
   logic [31:0]       trc_instr;
   logic [TSW-1:0]    trc_ts;
   logic [3:0]        trc_lvl;
   logic              ovf;
   logic [15:0]       drop_cnt;
   logic [15:0]       hit_cnt;

   always #5 clk = ~clk;

   scr1_imem_cmd_tracer #(
      .TRC_DEPTH (DEPTH),
      .TRC_TS_W  (TSW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_resp      (imem_resp),
      .imem_rdata     (imem_rdata),
      .curr_pc        (curr_pc),
      .cfg_en         (cfg_en),
      .cfg_wr         (cfg_wr),
      .cfg_wdata_val  (cfg_wdata_val),
      .cfg_wdata_mask (cfg_wdata_mask),
      .cfg_clr        (cfg_clr),
      .trc_vd         (trc_vd),
      .trc_rdy        (trc_rdy),
      .trc_pc         (trc_pc),
      .trc_instr      (trc_instr),
      .trc_ts         (trc_ts),
      .trc_lvl        (trc_lvl),
      .ovf            (ovf),
      .drop_cnt       (drop_cnt),
      .hit_cnt        (hit_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Expected-record queue and statistics model.
   type_scr1_trc_entry_s sb_q[$];
   logic        exp_hit = 1'b0;
   logic        mon_en  = 1'b0;
   int          mon_pops = 0;
   int          mdl_pops = 0;
   logic [31:0] m_ts  = '0;
   int          m_hit = 0;
   int          m_drop = 0;
   logic        m_ovf = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: at each edge, apply the expected push/drop for the cycle just ended.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            sb_q.delete();
            m_ts = '0; m_hit = 0; m_drop = 0; m_ovf = 1'b0;
            mdl_pops = mon_pops;
         end else begin
            int   lvl_before;
            logic popping;
            type_scr1_trc_entry_s e;
            popping    = (mon_pops != mdl_pops);
            lvl_before = sb_q.size() + (popping ? 1 : 0);
            mdl_pops   = mon_pops;
            if (exp_hit && (lvl_before < DEPTH || popping)) begin
               e.pc = curr_pc; e.instr = imem_rdata; e.ts = m_ts;
               sb_q.push_back(e);
            end
            if (cfg_clr) begin
               m_hit = 0; m_drop = 0; m_ovf = 1'b0;
            end else if (exp_hit) begin
               if (m_hit < 65535) m_hit++;
               if (!(lvl_before < DEPTH || popping)) begin
                  m_ovf = 1'b1;
                  if (m_drop < 65535) m_drop++;
               end
            end
            m_ts = m_ts + 1;
         end
      end
   end

   // Monitor: sample mid-cycle, compare the head and stats, retire popped records.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("trc_vd", trc_vd, sb_q.size() > 0);
            chk("trc_lvl", trc_lvl, sb_q.size());
            chk("hit_cnt", hit_cnt, m_hit);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("ovf", ovf, m_ovf);
            if (sb_q.size() > 0) begin
               chk("head_pc", trc_pc, sb_q[0].pc);
               chk("head_instr", trc_instr, sb_q[0].instr);
               chk("head_ts", trc_ts, sb_q[0].ts);
               if (trc_rdy) begin
                  void'(sb_q.pop_front());
                  mon_pops++;
               end
            end else begin
               chk("idle_pc", trc_pc, 0);
               chk("idle_instr", trc_instr, 0);
               chk("idle_ts", trc_ts, 0);
            end
         end
      end
   end

   // Drive one cycle starting at posedge+1; eh is the hand-computed hit flag.
   task automatic step(input logic [1:0] r, input logic [31:0] d,
                       input logic [31:0] p, input logic eh);
      imem_resp = r; imem_rdata = d; curr_pc = p; exp_hit = eh;
      @(posedge clk); #1;
      imem_resp = SCR1_TRC_RESP_IDLE; exp_hit = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(SCR1_TRC_RESP_IDLE, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic clr_pulse();
      cfg_clr = 1'b1; idle(1); cfg_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_resp = 2'b00; imem_rdata = '0; curr_pc = '0;
      cfg_en = 1'b1; cfg_wr = 1'b0; cfg_wdata_val = '0; cfg_wdata_mask = '0;
      cfg_clr = 1'b0; trc_rdy = 1'b0;
      @(posedge clk); mon_en = 1'b1;
      @(posedge clk); #1; rst = 1'b0;

      // Reset state
      chk("rst_vd", trc_vd, 0);
      chk("rst_lvl", trc_lvl, 0);
      chk("rst_hit", hit_cnt, 0);
      chk("rst_ovf", ovf, 0);

      // 1: default pattern hit, timestamp 1
      idle(1);
      step(2'b01, 32'h057E4505, 32'h200, 1'b1);
      chk("t1_vd", trc_vd, 1);
      chk("t1_pc", trc_pc, 32'h200);
      chk("t1_instr", trc_instr, 32'h057E4505);
      chk("t1_ts", trc_ts, 1);
      chk("t1_hit", hit_cnt, 1);
      trc_rdy = 1'b1; idle(1); trc_rdy = 1'b0;

      // 2: ERROR / reserved codes and a 1-bit mismatch never hit
      clr_pulse();
      step(2'b10, 32'h057E4505, 32'h204, 1'b0);
      step(2'b01, 32'h057E4504, 32'h208, 1'b0);
      step(2'b11, 32'h057E4505, 32'h20C, 1'b0);
      step(2'b00, 32'h057E4505, 32'h210, 1'b0);
      idle(1);
      chk("t2_lvl", trc_lvl, 0);
      chk("t2_hit", hit_cnt, 0);

      // 3: new pattern; the cfg_wr cycle still compares with the old one
      cfg_wr = 1'b1; cfg_wdata_val = 32'h0000_0013; cfg_wdata_mask = 32'h0000_007F;
      step(2'b01, 32'h057E4505, 32'h300, 1'b1);
      cfg_wr = 1'b0;
      step(2'b01, 32'h00A0_0513, 32'h304, 1'b1);
      step(2'b01, 32'h00A0_0533, 32'h308, 1'b0);
      step(2'b01, 32'h057E4505, 32'h30C, 1'b0);
      cfg_en = 1'b0;
      step(2'b01, 32'h0000_0013, 32'h310, 1'b0);
      chk("t3_lvl_en_off", trc_lvl, 2);
      cfg_en = 1'b1;
      trc_rdy = 1'b1; idle(3); trc_rdy = 1'b0;
      chk("t3_hit", hit_cnt, 2);
      chk("t3_lvl", trc_lvl, 0);

      // 4: overflow with 10 hits into 8 entries, drain, then clear
      clr_pulse();
      for (int i = 0; i < 10; i++)
         step(2'b01, 32'h0000_0013 | (i << 8), 32'h400 + 4 * i, 1'b1);
      idle(1);
      chk("t4_lvl", trc_lvl, 8);
      chk("t4_drop", drop_cnt, 2);
      chk("t4_ovf", ovf, 1);
      chk("t4_hit", hit_cnt, 10);
      trc_rdy = 1'b1; idle(8); trc_rdy = 1'b0;
      chk("t4_lvl_drained", trc_lvl, 0);
      clr_pulse();
      chk("t4_clr_ovf", ovf, 0);
      chk("t4_clr_drop", drop_cnt, 0);

      // 5: full + hit + pop in one cycle, then clear racing a drop
      for (int i = 0; i < 8; i++)
         step(2'b01, 32'h0000_1013 | (i << 16), 32'h500 + 4 * i, 1'b1);
      trc_rdy = 1'b1;
      step(2'b01, 32'hABCD_0013, 32'h5FC, 1'b1);
      trc_rdy = 1'b0;
      chk("t5_lvl", trc_lvl, 8);
      chk("t5_drop", drop_cnt, 0);
      cfg_clr = 1'b1;
      step(2'b01, 32'h0000_0093, 32'h5F8, 1'b1);
      cfg_clr = 1'b0;
      chk("t5_clr_ovf", ovf, 0);
      chk("t5_clr_drop", drop_cnt, 0);
      chk("t5_clr_hit", hit_cnt, 0);
      trc_rdy = 1'b1; idle(8); trc_rdy = 1'b0;

      // 6: reset mid-drain flushes and restarts the timestamp
      for (int i = 0; i < 3; i++)
         step(2'b01, 32'h0000_2013, 32'h600 + 4 * i, 1'b1);
      trc_rdy = 1'b1; idle(1);
      rst = 1'b1; idle(1);
      rst = 1'b0; trc_rdy = 1'b0;
      chk("t6_vd", trc_vd, 0);
      chk("t6_lvl", trc_lvl, 0);
      chk("t6_hit", hit_cnt, 0);
      step(2'b01, 32'h057E4505, 32'h700, 1'b1);
      chk("t6_ts", trc_ts, 0);
      chk("t6_pc", trc_pc, 32'h700);
      trc_rdy = 1'b1; idle(2); trc_rdy = 1'b0;

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scr1_imem_cmd_tracer.md
Name: scr1_imem_cmd_tracer

Overview:
Synthesizable capture stage sitting on the instruction-memory response path, directly downstream of the imem AHB router response.
- Each cycle with a valid fetch response, the fetched word is compared against a masked pattern.
- On a hit, the tuple {pc, instr, timestamp} is pushed into a small FIFO.
- A ready/valid drain port feeds a debug consumer (UART dumper or scratch RAM writer).
- Replaces print-only monitoring with a record that can be buffered and read back in silicon or in simulation.

Parameters:
TRC_DEPTH, 8, FIFO entries; power of two, range 2..64.
TRC_TS_W, 32, timestamp counter width in bits.
TRC_MATCH_RST, 32'h057E4505, reset value of cfg_match_val.
TRC_MASK_RST, 32'hFFFFFFFF, reset value of cfg_match_mask.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
imem_resp  in  2  fetch response code: 00 IDLE, 01 OKAY, 10 ERROR
imem_rdata  in  32  fetched instruction word
curr_pc  in  32  PC associated with the current response
cfg_en  in  1  capture enable
cfg_wr  in  1  one-cycle strobe; loads cfg_match_val and cfg_match_mask from cfg_wdata_val and cfg_wdata_mask
cfg_wdata_val  in  32  new match value
cfg_wdata_mask  in  32  new match mask; 1 = bit compared
cfg_clr  in  1  one-cycle strobe; clears ovf, drop_cnt and hit_cnt
trc_vd  out  1  FIFO head valid
trc_rdy  in  1  consumer ready
trc_pc  out  32  head PC
trc_instr  out  32  head instruction word
trc_ts  out  TRC_TS_W  head timestamp
trc_lvl  out  $clog2(TRC_DEPTH)+1  current occupancy
ovf  out  1  sticky: at least one hit was dropped
drop_cnt  out  16  dropped hits, saturating
hit_cnt  out  16  total hits, saturating

Behaviour:
- Reset is synchronous and active-high; rst sampled at the rising edge of clk.
- Reset values:
  - trc_vd = 0, trc_lvl = 0, ovf = 0, drop_cnt = 0, hit_cnt = 0, timestamp = 0.
  - cfg_match_val = TRC_MATCH_RST, cfg_match_mask = TRC_MASK_RST.
  - trc_pc, trc_instr and trc_ts = 0 while trc_vd = 0.
- Timestamp: free-running counter, +1 every cycle not in reset; wraps modulo 2^TRC_TS_W with no flag.
- Hit condition (combinational):
  - hit = cfg_en && imem_resp == 2'b01 && ((imem_rdata ^ cfg_match_val) & cfg_match_mask) == 0.
  - Responses with code 00, 10 or 11 never hit.
  - Mask of all zeros makes every OKAY response a hit.
- Latency: a hit at edge N is written to the FIFO at edge N.
  - Empty FIFO: trc_vd = 1 with that entry after edge N (next cycle); no bypass.
  - Captured timestamp = counter value in the hit cycle.
- Drain: pop occurs on an edge where trc_vd && trc_rdy.
  - Head outputs are stable while trc_vd && !trc_rdy.
  - trc_rdy with trc_vd = 0 has no effect.
- FIFO boundaries:
  - Full and hit with no pop: entry dropped, ovf <= 1, drop_cnt += 1 (saturates at 16'hFFFF), hit_cnt still increments.
  - Full and hit with a pop in the same cycle: push accepted, trc_lvl unchanged, no drop.
  - Empty: only a push can occur; a pop cannot.
  - Pointers are log2(TRC_DEPTH) bits and wrap naturally; full/empty derived from an occupancy counter.
- Config:
  - cfg_wr takes effect from the next cycle's compare.
  - A hit in the same cycle as cfg_wr uses the old pattern.
  - cfg_en may toggle at any time; already-buffered entries remain drainable.
- cfg_clr with a simultaneous drop: the clear wins, so ovf = 0 and counters = 0. The FIFO is not flushed.
- Reset mid-operation: FIFO flushed, all state returns to reset values; any entry at the FIFO head is lost.
- hit_cnt saturates at 16'hFFFF.

Decomposition:
- Shared package scr1_trc_pkg:
  - typedef of the response codes: IDLE = 2'b00, OKAY = 2'b01, ERROR = 2'b10.
  - struct type_scr1_trc_entry_s {pc, instr, ts}.
  - Constants for the reset match value and mask.
- One sub-module: scr1_trc_fifo.
  - Generic synchronous FIFO, parameterized on depth and an entry-type width.
  - Ports: push, pop, full, empty, level.
- The top module holds the comparator, timestamp counter, statistics counters and config registers.

Test Plan:
1. Reset, cfg defaults; drive imem_resp = 01, imem_rdata = 32'h057E4505, curr_pc = 32'h0000_0200, one cycle -> next cycle trc_vd = 1, trc_pc = 0x200, trc_instr = 0x057E4505, trc_ts = 1 (counter value in the hit cycle), hit_cnt = 1.
2. Same word with imem_resp = 10, then imem_rdata = 32'h057E4504 with resp = 01 -> no push; trc_lvl = 0, hit_cnt = 0.
3. cfg_wr with val = 32'h0000_0013, mask = 32'h0000_007F; fetch 32'h00A0_0513 -> hit; fetch 32'h00A0_0533 -> no hit.
4. trc_rdy = 0, TRC_DEPTH = 8, 10 consecutive hits -> trc_lvl = 8, drop_cnt = 2, ovf = 1, hit_cnt = 10; drain 8 entries in order with increasing ts; then cfg_clr -> ovf = 0, drop_cnt = 0.
5. FIFO full, hit and trc_rdy = 1 in the same cycle -> trc_lvl stays 8, drop_cnt unchanged, new entry appears last.
6. Three hits buffered, assert rst for one cycle mid-drain -> trc_vd = 0, trc_lvl = 0, counters 0, next-cycle timestamp restarts from 0.
